// File: rtl/sram_error_logger.sv
// Queues SRAM comparator error events in a small FIFO and shifts them out one
// 32-bit parity-protected frame at a time, paced by a bit clock from the Pi.
module sram_error_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             err_valid_i,
    input  logic [14:0]      err_addr_i,
    input  logic [7:0]       err_expected_i,
    input  logic [7:0]       err_read_i,
    input  logic             clear_log_ni,
    input  logic             pi_clk_i,
    output logic             pi_data_o,
    output logic             pi_frame_o,
    output logic [3:0]       fifo_count_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] err_total_o
);

    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam logic [3:0]  CountFull = 4'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e            state_q, state_d;
    logic [30:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [3:0]        count_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  total_q;
    logic [31:0]       shreg_q;
    logic [4:0]        bit_idx_q;
    logic [2:0]        pi_sync_q;
    logic              tick, clear, pop, push, full;

    assign clear = ~clear_log_ni;
    assign tick  = pi_sync_q[1] & ~pi_sync_q[2];
    assign full  = (count_q == CountFull);
    assign pop   = (state_q == StLoad);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = err_valid_i & (~full | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pi_sync_q <= '0;
        end else begin
            pi_sync_q <= {pi_sync_q[1:0], pi_clk_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= {err_addr_i, err_expected_i, err_read_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + 4'(push) - 4'(pop);
            if (err_valid_i && !push) overflow_q <= 1'b1;
            if (err_valid_i && (total_q != '1)) total_q <= total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != 4'd0) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (tick && (bit_idx_q == 5'd31)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clear) state_d = StIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q   <= '0;
            bit_idx_q <= '0;
        end else if (clear) begin
            shreg_q   <= '0;
            bit_idx_q <= '0;
        end else if (state_q == StLoad) begin
            // Even parity in bit 31 makes the whole frame XOR to zero.
            shreg_q   <= {^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
            bit_idx_q <= '0;
        end else if ((state_q == StShift) && tick && (bit_idx_q != 5'd31)) begin
            shreg_q   <= {1'b0, shreg_q[31:1]};
            bit_idx_q <= bit_idx_q + 5'd1;
        end
    end

    always_comb begin
        pi_frame_o = (state_q == StShift);
        pi_data_o  = (state_q == StShift) & shreg_q[0];
    end

    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign err_total_o  = total_q;

endmodule

// File: tb/tb_sram_error_logger.sv
// Bench for sram_error_logger: directed scenarios plus random bursts, checked
// against a queue-based model of the logger's event flow.
`timescale 1ns/1ps
module tb_sram_error_logger;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        err_valid = 1'b0, clear_log_n = 1'b1, pi_clk = 1'b0;
    logic [14:0] err_addr = '0;
    logic [7:0]  err_exp = '0, err_read = '0;
    logic        pi_data, pi_frame, overflow;
    logic [3:0]  fifo_count;
    logic [15:0] err_total;

    logic        sat_valid = 1'b0;
    logic        s_data, s_frame, s_ovf;
    logic [3:0]  s_count;
    logic [3:0]  s_total;

    sram_error_logger #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .err_valid_i(err_valid), .err_addr_i(err_addr),
        .err_expected_i(err_exp), .err_read_i(err_read), .clear_log_ni(clear_log_n),
        .pi_clk_i(pi_clk), .pi_data_o(pi_data), .pi_frame_o(pi_frame),
        .fifo_count_o(fifo_count), .overflow_o(overflow), .err_total_o(err_total)
    );

    sram_error_logger #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .err_valid_i(sat_valid), .err_addr_i(15'h0),
        .err_expected_i(8'h0), .err_read_i(8'h0), .clear_log_ni(1'b1),
        .pi_clk_i(1'b0), .pi_data_o(s_data), .pi_frame_o(s_frame),
        .fifo_count_o(s_count), .overflow_o(s_ovf), .err_total_o(s_total)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Model: queued events, the frame held by the serializer, and its load delay.
    logic [30:0] mq[$];
    logic [30:0] m_frame;
    bit          m_busy, m_wait, m_ovf;
    int unsigned m_total, m_sat;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_busy  = 0;
        m_wait  = 0;
        m_ovf   = 0;
        m_total = 0;
    endfunction

    function automatic void model_edge(bit v, logic [30:0] ev, bit clr, bit fin);
        int sz;
        bit pop;
        sz = mq.size();
        if (clr) begin
            model_reset();
            return;
        end
        pop = m_wait;
        if (v) begin
            if (m_total < 32'hffff) m_total++;
            if (sz < DEPTH || pop) mq.push_back(ev);
            else m_ovf = 1;
        end
        if (pop) begin
            m_frame = mq.pop_front();
            m_busy  = 1;
            m_wait  = 0;
        end else if (!m_busy && sz > 0) begin
            m_wait = 1;
        end
        if (fin) m_busy = 0;
    endfunction

    function automatic logic [31:0] frame_of(logic [30:0] e);
        return {^e, e};
    endfunction

    task automatic cyc(bit v = 0, logic [30:0] ev = '0, bit clr = 0, bit fin = 0, bit sv = 0);
        err_valid   = v;
        {err_addr, err_exp, err_read} = ev;
        clear_log_n = ~clr;
        sat_valid   = sv;
        @(posedge clk);
        model_edge(v, ev, clr, fin);
        if (sv && m_sat < 15) m_sat++;
        #1;
        err_valid   = 1'b0;
        clear_log_n = 1'b1;
        sat_valid   = 1'b0;
    endtask

    function automatic logic [30:0] rand_ev();
        return 31'($urandom());
    endfunction

    // Pi side: sample on the low phase, then raise pi_clk for three cycles.
    task automatic read_frame(int nbits, string tag);
        logic [31:0] got, exp, mask;
        got  = '0;
        exp  = '0;
        mask = (nbits >= 32) ? 32'hffff_ffff : ((32'd1 << nbits) - 32'd1);
        for (int k = 0; k < nbits; k++) begin
            repeat (3) cyc();
            if (k == 0) begin
                chk({tag, "_frame_hi"}, pi_frame, m_busy);
                exp = frame_of(m_frame);
            end
            got[k] = pi_data;
            pi_clk = 1'b1;
            cyc();
            cyc();
            cyc(.fin(k == 31));
            pi_clk = 1'b0;
        end
        chk({tag, "_bits"}, got & mask, exp & mask);
        if (nbits == 32) chk({tag, "_parity"}, 32'(^got), 32'd0);
    endtask

    task automatic drain(string tag);
        int guard = 0;
        while ((mq.size() > 0 || m_busy || m_wait) && guard < 3 * DEPTH) begin
            read_frame(32, tag);
            guard++;
        end
        repeat (3) cyc();
        chk({tag, "_drained_cnt"}, fifo_count, 32'd0);
        chk({tag, "_drained_frm"}, pi_frame, 32'd0);
    endtask

    task automatic check_status(string tag);
        chk({tag, "_count"}, fifo_count, 32'(mq.size()));
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_total"}, err_total, m_total);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [30:0] ev;
        int n, g;
        model_reset();
        m_sat = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", pi_data, 0);
        chk("rst_frame", pi_frame, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_total", err_total, 0);
        rst_n = 1'b1;
        cyc();

        // Single event: frame appears two cycles after the push.
        ev = {15'h1234, 8'hA5, 8'hA4};
        cyc(.v(1), .ev(ev));
        cyc();
        chk("single_frame_early", pi_frame, 0);
        cyc();
        chk("single_frame_rise", pi_frame, 1);
        chk("single_bit0", pi_data, 0);
        read_frame(32, "single");
        repeat (3) cyc();
        chk("single_frame_end", pi_frame, 0);
        check_status("single");

        // Full FIFO with a push landing on the LOAD cycle.
        cyc(.clr(1));
        for (int i = 0; i < DEPTH + 1; i++) cyc(.v(1), .ev(rand_ev()));
        cyc();
        check_status("full");
        read_frame(32, "full_f0");
        g = 0;
        while (!m_wait && g < 10) begin
            cyc();
            g++;
        end
        cyc(.v(1), .ev(rand_ev()));
        check_status("loadpush");
        chk("loadpush_ovf0", overflow, 0);
        drain("loadpush");

        // Overflow: ten pushes with the Pi idle.
        cyc(.clr(1));
        for (int i = 0; i < 10; i++) cyc(.v(1), .ev(rand_ev()));
        cyc();
        check_status("ovf");
        chk("ovf_count8", fifo_count, 8);
        chk("ovf_total10", err_total, 10);
        drain("ovf");

        // clear_log mid-frame wins over a same-cycle event.
        for (int i = 0; i < 3; i++) cyc(.v(1), .ev(rand_ev()));
        read_frame(10, "clr_part");
        cyc(.v(1), .ev(rand_ev()), .clr(1));
        chk("clr_frame", pi_frame, 0);
        chk("clr_count", fifo_count, 0);
        chk("clr_total", err_total, 0);
        chk("clr_ovf", overflow, 0);
        repeat (4) cyc();
        chk("clr_stay_idle", pi_frame, 0);

        // Random bursts with random gaps.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                cyc(.v(1), .ev(rand_ev()));
                g = $urandom_range(0, 2);
                repeat (g) cyc();
            end
            repeat (3) cyc();
            check_status("rnd");
            drain("rnd");
            cyc(.clr(1));
            check_status("rnd_clr");
        end

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 2; i++) cyc(.v(1), .ev(rand_ev()));
        read_frame(5, "arst_part");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", pi_data, 0);
        chk("arst_frame", pi_frame, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_total", err_total, 0);
        model_reset();
        m_sat = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cyc();
        chk("arst_after_frame", pi_frame, 0);
        chk("arst_after_count", fifo_count, 0);

        // Saturating counter on the narrow build.
        for (int i = 0; i < 20; i++) cyc(.sv(1));
        chk("sat_total", s_total, m_sat);
        cyc();
        cyc();
        chk("sat_hold", s_total, m_sat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
